// File: rtl/d_mem_arbiter_if.sv
// rtl/d_mem_arbiter_if.sv - CPU, EXT and memory signal bundle for the data memory arbiter
interface d_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  // CPU load/store side
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvld;
  // EXT (DMA/debug) side
  logic              ext_req;
  logic              ext_wr;
  logic              ext_last;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvld;
  // single-port memory side
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter view
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvld,
    input  ext_req, ext_wr, ext_last, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvld,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requester/memory environment view
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvld,
    output ext_req, ext_wr, ext_last, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvld,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// rtl/d_mem_arbiter.sv - data memory arbiter (CPU vs EXT) with locked EXT bursts; optional macro D_MEM_ARB_RR_EN
module d_mem_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 8,
  parameter int MAX_EXT_WAIT  = 4,
  parameter int MAX_EXT_BURST = 8
) (
  input  logic           clk,
  input  logic           reset_,
  d_mem_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_EXT_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_EXT_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_EXT_LOCK = 1'b1
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          cpu_rd_tag_q;
  logic          ext_rd_tag_q;

  logic          cpu_req;
  logic          cpu_is_wr;
  logic          cpu_win;
  logic          ext_win;
  logic          burst_full;

`ifdef D_MEM_ARB_RR_EN
  // 1 = EXT won the most recent grant, so CPU is next on contention
  logic          last_ext_q, last_ext_d;
`else
  localparam int WW = $clog2(MAX_EXT_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_EXT_WAIT);
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // a simultaneous rd+wr request is handled as a write
  assign cpu_req    = bus.cpu_rd | bus.cpu_wr;
  assign cpu_is_wr  = bus.cpu_wr;
  assign burst_full = (burst_cnt_q == BURST_MAX);

  // state register, counters and read-owner tags
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ARB_IDLE;
      burst_cnt_q  <= '0;
      cpu_rd_tag_q <= 1'b0;
      ext_rd_tag_q <= 1'b0;
`ifdef D_MEM_ARB_RR_EN
      last_ext_q   <= 1'b1;
`else
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rd_tag_q <= cpu_win & ~cpu_is_wr;
      ext_rd_tag_q <= ext_win & ~bus.ext_wr;
`ifdef D_MEM_ARB_RR_EN
      last_ext_q   <= last_ext_d;
`else
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  // next-state: lock entry/exit, burst length and fairness bookkeeping
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (ext_win && !bus.ext_last) begin
          state_d     = ARB_EXT_LOCK;
          burst_cnt_d = BURST_ONE;
        end
      end
      ARB_EXT_LOCK: begin
        if (cpu_win || (ext_win && bus.ext_last)) begin
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
        end else if (ext_win && !burst_full) begin
          burst_cnt_d = burst_cnt_q + BURST_ONE;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        burst_cnt_d = '0;
      end
    endcase
`ifdef D_MEM_ARB_RR_EN
    last_ext_d = last_ext_q;
    if (cpu_win) begin
      last_ext_d = 1'b0;
    end else if (ext_win) begin
      last_ext_d = 1'b1;
    end
`else
    wait_cnt_d = wait_cnt_q;
    if (ext_win) begin
      wait_cnt_d = '0;
    end else if (bus.ext_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
`endif
  end

  // grant decision; an exhausted lock hands the next slot straight to a waiting CPU
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (reset_) begin
      unique case (state_q)
        ARB_IDLE: begin
`ifdef D_MEM_ARB_RR_EN
          cpu_win = (cpu_req && bus.ext_req) ? last_ext_q : cpu_req;
`else
          cpu_win = cpu_req && (wait_cnt_q != WAIT_MAX);
`endif
          ext_win = bus.ext_req && !cpu_win;
        end
        ARB_EXT_LOCK: begin
          cpu_win = cpu_req && burst_full;
          ext_win = bus.ext_req && !cpu_win;
        end
        default: begin
          cpu_win = 1'b0;
          ext_win = 1'b0;
        end
      endcase
    end
  end

  // outputs: memory mux from the winner, stall/grant, and tagged read return
  always_comb begin
    bus.mem_en    = cpu_win | ext_win;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_win) begin
      bus.mem_wr    = cpu_is_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (ext_win) begin
      bus.mem_wr    = bus.ext_wr;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
    bus.cpu_stall = reset_ & cpu_req & ~cpu_win;
    bus.ext_gnt   = ext_win;
    bus.cpu_rvld  = cpu_rd_tag_q;
    bus.ext_rvld  = ext_rd_tag_q;
    bus.cpu_rdata = cpu_rd_tag_q ? bus.mem_rdata : '0;
    bus.ext_rdata = ext_rd_tag_q ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb/tb_d_mem_arbiter.sv - randomized self-checking bench for d_mem_arbiter against a behavioural model
module tb_d_mem_arbiter;
  localparam int AW        = 12;
  localparam int DW        = 8;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;
`ifdef D_MEM_ARB_RR_EN
  localparam int T2_EXT_WINS = 5;
`else
  localparam int T2_EXT_WINS = 2;
`endif

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  d_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  d_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_EXT_WAIT(MAX_WAIT), .MAX_EXT_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .bus(bus)
  );

  // physical single-port memory behind the arbiter
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_locked;
  int            m_burst, m_wait;
  bit            m_last_ext;
  int            m_rtag;          // 0 none, 1 cpu, 2 ext
  logic [DW-1:0] m_rexp;
  bit            g_cpu, g_ext;

  task automatic model_reset();
    m_locked = 0; m_burst = 0; m_wait = 0; m_last_ext = 1; m_rtag = 0; m_rexp = '0;
    g_cpu = 0; g_ext = 0;
  endtask

  task automatic step_check();
    bit creq, cg, eg;
    logic [AW-1:0] a;
    chk("cpu_rvld", bus.cpu_rvld, m_rtag == 1);
    chk("cpu_rdata", bus.cpu_rdata, (m_rtag == 1) ? m_rexp : '0);
    chk("ext_rvld", bus.ext_rvld, m_rtag == 2);
    chk("ext_rdata", bus.ext_rdata, (m_rtag == 2) ? m_rexp : '0);
    creq = bus.cpu_rd | bus.cpu_wr;
    if (!m_locked) begin
`ifdef D_MEM_ARB_RR_EN
      cg = (creq && bus.ext_req) ? m_last_ext : creq;
`else
      cg = creq && (m_wait < MAX_WAIT);
`endif
    end else begin
      cg = creq && (m_burst >= MAX_BURST);
    end
    eg = bus.ext_req && !cg;
    chk("cpu_stall", bus.cpu_stall, creq && !cg);
    chk("ext_gnt", bus.ext_gnt, eg);
    chk("mem_en", bus.mem_en, cg || eg);
    chk("mem_wr", bus.mem_wr, cg ? bus.cpu_wr : (eg ? bus.ext_wr : 1'b0));
    chk("mem_addr", bus.mem_addr, cg ? bus.cpu_addr : (eg ? bus.ext_addr : '0));
    chk("mem_wdata", bus.mem_wdata, cg ? bus.cpu_wdata : (eg ? bus.ext_wdata : '0));
    // advance model
    if (!m_locked) begin
      if (eg && !bus.ext_last) begin m_locked = 1; m_burst = 1; end
    end else if (cg || (eg && bus.ext_last)) begin
      m_locked = 0; m_burst = 0;
    end else if (eg && m_burst < MAX_BURST) begin
      m_burst++;
    end
    if (eg) m_wait = 0;
    else if (bus.ext_req && m_wait < MAX_WAIT) m_wait++;
    if (cg) m_last_ext = 0;
    else if (eg) m_last_ext = 1;
    m_rtag = 0;
    if (cg || eg) begin
      a = cg ? bus.cpu_addr : bus.ext_addr;
      if (cg ? bus.cpu_wr : bus.ext_wr) ref_mem[a] = cg ? bus.cpu_wdata : bus.ext_wdata;
      else begin m_rtag = cg ? 1 : 2; m_rexp = ref_mem[a]; end
    end
    g_cpu = cg; g_ext = eg;
  endtask

  task automatic cycle();
    @(negedge clk);
    step_check();
    @(posedge clk);
    #1;
  endtask

  // ---------------- requester agents ----------------
  int e_left, e_idx, e_base, e_seed, e_step;
  bit e_wr, e_gaps;

  task automatic cpu_drive(input int mode);
    int r;
    if ((bus.cpu_rd || bus.cpu_wr) && !g_cpu) return;
    bus.cpu_rd = 0; bus.cpu_wr = 0;
    if (mode == 2 || (mode == 1 && $urandom_range(0, 4) < 2)) begin
      r = $urandom_range(0, 2);
      bus.cpu_rd    = (r != 1);
      bus.cpu_wr    = (r != 0);
      bus.cpu_addr  = AW'($urandom_range(32, 79));
      bus.cpu_wdata = DW'($urandom);
    end
  endtask

  task automatic ext_drive();
    if (bus.ext_req && !g_ext) return;
    if (bus.ext_req && g_ext) begin e_left--; e_idx++; end
    bus.ext_req = 0; bus.ext_last = 0;
    if (e_left == 0) return;
    if (e_gaps && $urandom_range(0, 3) == 0) return;
    bus.ext_req   = 1;
    bus.ext_wr    = e_wr;
    bus.ext_last  = (e_left == 1);
    bus.ext_addr  = AW'(e_base + e_idx);
    bus.ext_wdata = DW'(e_seed + e_idx * e_step);
  endtask

  task automatic ext_start(input int base, input int len, input bit wr,
                           input int seed, input int step, input bit gaps);
    e_base = base; e_left = len; e_idx = 0; e_wr = wr;
    e_seed = seed; e_step = step; e_gaps = gaps;
    ext_drive();
  endtask

  task automatic quiesce();
    for (int i = 0; i < 60 && (bus.cpu_rd || bus.cpu_wr || bus.ext_req); i++) begin
      cycle(); cpu_drive(0); ext_drive();
    end
    chk("quiesce", {bus.cpu_rd, bus.cpu_wr, bus.ext_req}, 3'b000);
    cycle(); cycle();
  endtask

  task automatic clear_inputs();
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_wr = 0; bus.ext_last = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    e_left = 0; e_idx = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    clear_inputs();
    mem_clr = 1;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    model_reset();

    // reset state with requests pending
    bus.cpu_rd = 1; bus.ext_req = 1;
    #12;
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_ext_gnt", bus.ext_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_cpu_rvld", bus.cpu_rvld, 0);
    chk("rst_ext_rvld", bus.ext_rvld, 0);
    @(posedge clk); #1;
    mem_clr = 0;
    clear_inputs();
    reset_ = 1;

    // CPU-only: write 0xA5 to 0x123, then read it back
    bus.cpu_wr = 1; bus.cpu_addr = 12'h123; bus.cpu_wdata = 8'hA5;
    cycle();
    bus.cpu_wr = 0; bus.cpu_rd = 1;
    #1;
    chk("t1_mem_en", bus.mem_en, 1);
    chk("t1_mem_addr", bus.mem_addr, 12'h123);
    chk("t1_stall", bus.cpu_stall, 0);
    cycle();
    chk("t1_cpu_rvld", bus.cpu_rvld, 1);
    chk("t1_cpu_rdata", bus.cpu_rdata, 8'hA5);
    bus.cpu_rd = 0;
    cycle();

    // both requesting continuously, single-beat EXT reads
    bus.cpu_rd = 1; bus.cpu_addr = 12'h005;
    bus.ext_req = 1; bus.ext_wr = 0; bus.ext_last = 1; bus.ext_addr = 12'h006;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.ext_gnt) n++;
      cycle();
    end
    chk("t2_ext_wins", n, T2_EXT_WINS);
    clear_inputs();
    cycle(); cycle();

    // 3-beat EXT write burst against a busy CPU
    cpu_drive(2);
    ext_start(12'h010, 3, 1, 8'h11, 8'h11, 0);
    for (int i = 0; i < 40 && e_left != 0; i++) begin
      cycle(); cpu_drive(2); ext_drive();
    end
    chk("t3_done", e_left, 0);
    quiesce();
    chk("t3_mem0", mem[12'h010], 8'h11);
    chk("t3_mem1", mem[12'h011], 8'h22);
    chk("t3_mem2", mem[12'h012], 8'h33);

    // 20-beat burst, CPU always waiting: lock must be broken and resumed
    cpu_drive(2);
    ext_start(12'h100, 20, 1, 8'h40, 1, 0);
    for (int i = 0; i < 120 && e_left != 0; i++) begin
      cycle(); cpu_drive(2); ext_drive();
    end
    chk("t4_done", e_left, 0);
    quiesce();
    chk("t4_last_beat", mem[12'h113], 8'h53);

    // alternating reads return in grant order
    bus.cpu_wr = 1; bus.cpu_addr = 12'h001; bus.cpu_wdata = 8'h5A; cycle();
    bus.cpu_addr = 12'h002; bus.cpu_wdata = 8'hC3; cycle();
    bus.cpu_wr = 0; bus.cpu_rd = 1; bus.cpu_addr = 12'h001;
    bus.ext_req = 1; bus.ext_wr = 0; bus.ext_last = 1; bus.ext_addr = 12'h002;
    cycle();
    chk("t5_first_rdata", g_cpu ? bus.cpu_rdata : bus.ext_rdata, g_cpu ? 8'h5A : 8'hC3);
    chk("t5_first_both", bus.cpu_rvld & bus.ext_rvld, 0);
    if (g_cpu) bus.cpu_rd = 0; else bus.ext_req = 0;
    cycle();
    chk("t5_second_rvld", bus.cpu_rvld + bus.ext_rvld, 1);
    chk("t5_second_rdata", bus.cpu_rvld ? bus.cpu_rdata : bus.ext_rdata,
        bus.cpu_rvld ? 8'h5A : 8'hC3);
    clear_inputs();
    cycle(); cycle();

    // asynchronous reset in the middle of a locked read burst
    ext_start(12'h200, 10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin cycle(); ext_drive(); end
    #2;
    reset_ = 0;
    #1;
    chk("t6_ext_gnt", bus.ext_gnt, 0);
    chk("t6_mem_en", bus.mem_en, 0);
    chk("t6_mem_addr", bus.mem_addr, 0);
    chk("t6_ext_rvld", bus.ext_rvld, 0);
    chk("t6_cpu_stall", bus.cpu_stall, 0);
    clear_inputs();
    model_reset();
    @(negedge clk); @(posedge clk); #1;
    reset_ = 1;
    bus.cpu_rd = 1; bus.cpu_addr = 12'h123;
    bus.ext_req = 1; bus.ext_wr = 0; bus.ext_last = 0; bus.ext_addr = 12'h200;
    #1;
    chk("t6_post_stall", bus.cpu_stall, 0);
    chk("t6_post_ext_gnt", bus.ext_gnt, 0);
    cycle();
    chk("t6_post_rdata", bus.cpu_rdata, 8'hA5);
    clear_inputs();
    cycle(); cycle();

    // randomized mixed traffic
    for (int i = 0; i < 1500; i++) begin
      cycle();
      cpu_drive(1);
      ext_drive();
      if (e_left == 0 && !bus.ext_req && $urandom_range(0, 5) == 0)
        ext_start($urandom_range(0, 63), $urandom_range(1, 20), 1'($urandom),
                  $urandom_range(0, 255), $urandom_range(1, 7), 1);
    end
    quiesce();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
